pool_out_packer: RTL

Write-side companion to the pooling stage: consumes the pooled vector stream (`in_data` / `in_data_available` / `done_pool`) and packs the sparsely populated pooled vectors into full-width words written sequentially to the output BRAM. With kernel size K, each pooled beat carries MAT_MUL_SIZE/K valid lanes in its low lanes. The block collects K beats per BRAM word, flushes a partial word when pooling ends, and reports completion to the top-level control FSM.

---
 rtl/pool_out_packer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pool_out_packer.sv
// pool_out_packer: packs sparse pooled vectors (N/K valid low lanes per beat) into full BRAM words.
// Optional feature macro POOL_PACK_ZERO_PAD_EN: clear the pack register after every write.
`default_nettype none

module pool_out_packer #(
    parameter int DWIDTH        = 8,
    parameter int MAT_MUL_SIZE  = 4,
    parameter int AWIDTH        = 10,
    parameter int MAX_BITS_POOL = 3
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            start,
    input  logic [AWIDTH-1:0]               base_addr,
    input  logic                            enable_pool,
    input  logic [MAX_BITS_POOL-1:0]        kernel_size,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0]  in_data,
    input  logic                            in_data_available,
    input  logic                            done_pool,
    output logic [AWIDTH-1:0]               bram_addr,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0]  bram_wdata,
    output logic                            bram_we,
    output logic                            busy,
    output logic                            done_pack,
    output logic                            cfg_err
);

    localparam int VW = MAT_MUL_SIZE * DWIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          klog_q, klog_d;
    logic [2:0]          fill_q, fill_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [VW-1:0]       pack_q, pack_d;
    logic [AWIDTH-1:0]   bram_addr_q, bram_addr_d;
    logic [VW-1:0]       bram_wdata_q, bram_wdata_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cfg_err_q, cfg_err_d;
    int                  lpb;
    int                  lane_base;

    always_comb begin
        state_d      = state_q;
        klog_d       = klog_q;
        fill_d       = fill_q;
        addr_d       = addr_q;
        pack_d       = pack_q;
        bram_addr_d  = bram_addr_q;
        bram_wdata_d = bram_wdata_q;
        we_d         = 1'b0;
        cfg_err_d    = cfg_err_q;
        lpb          = MAT_MUL_SIZE >> klog_q;
        lane_base    = int'(fill_q) * lpb;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_ACCUM;
                    addr_d    = base_addr;
                    fill_d    = 3'd0;
                    pack_d    = '0;
                    klog_d    = 2'd0;
                    cfg_err_d = 1'b0;
                    if (enable_pool) begin
                        if (kernel_size == MAX_BITS_POOL'(2))      klog_d = 2'd1;
                        else if (kernel_size == MAX_BITS_POOL'(4)) klog_d = 2'd2;
                        else if (kernel_size != MAX_BITS_POOL'(1)) cfg_err_d = 1'b1;
                    end
                end
            end
            S_ACCUM: begin
                if (in_data_available) begin
                    for (int j = 0; j < MAT_MUL_SIZE; j++) begin
                        if (j >= lane_base && j < lane_base + lpb)
                            pack_d[j*DWIDTH +: DWIDTH] = in_data[(j-lane_base)*DWIDTH +: DWIDTH];
                    end
                    fill_d = fill_q + 3'd1;
                    if (fill_d == (3'd1 << klog_q)) begin
                        we_d         = 1'b1;
                        bram_addr_d  = addr_q;
                        bram_wdata_d = pack_d;
                        addr_d       = addr_q + AWIDTH'(1);
                        fill_d       = 3'd0;
`ifdef POOL_PACK_ZERO_PAD_EN
                        pack_d       = '0;
`endif
                    end
                end else if (done_pool) begin
                    state_d = (fill_q != 3'd0) ? S_FLUSH : S_DONE;
                end
            end
            S_FLUSH: begin
                we_d         = 1'b1;
                bram_addr_d  = addr_q;
                bram_wdata_d = pack_q;
                addr_d       = addr_q + AWIDTH'(1);
                fill_d       = 3'd0;
`ifdef POOL_PACK_ZERO_PAD_EN
                pack_d       = '0;
`endif
                state_d      = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_ACCUM) || (state_d == S_FLUSH);
        // done_pack waits one cycle behind a final flush write
        done_d = (state_d == S_DONE) && !we_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            klog_q       <= 2'd0;
            fill_q       <= 3'd0;
            addr_q       <= '0;
            pack_q       <= '0;
            bram_addr_q  <= '0;
            bram_wdata_q <= '0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            klog_q       <= klog_d;
            fill_q       <= fill_d;
            addr_q       <= addr_d;
            pack_q       <= pack_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
    assign bram_we    = we_q;
    assign busy       = busy_q;
    assign done_pack  = done_q;
    assign cfg_err    = cfg_err_q;

endmodule

`default_nettype wire
